// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush sequencer.
// The hold bus carries one 2-bit code per pipeline register, with field 0 being the PC.
package pipe_hold_ctrl_pkg;

    localparam int HOLD_W      = 2;
    localparam int STAGES      = 4;
    localparam int HOLD_BUS_W  = HOLD_W * STAGES;
    localparam int INST_ADDR_W = 32;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;

    localparam logic JUMP_ENABLE  = 1'b1;
    localparam logic JUMP_DISABLE = 1'b0;

    typedef enum logic [HOLD_W-1:0] {
        HOLD_NO    = 2'b00,
        HOLD_WAIT  = 2'b01,
        HOLD_FLUSH = 2'b10
    } hold_code_e;

    // Arguments are given in bus order, highest field first.
    function automatic logic [HOLD_BUS_W-1:0] pack_hold(
        input hold_code_e f3,
        input hold_code_e f2,
        input hold_code_e f1,
        input hold_code_e f0
    );
        return {f3, f2, f1, f0};
    endfunction

    localparam logic [HOLD_BUS_W-1:0] HOLD_ALL_NO    = {STAGES{HOLD_NO}};
    localparam logic [HOLD_BUS_W-1:0] HOLD_ALL_WAIT  = {STAGES{HOLD_WAIT}};
    localparam logic [HOLD_BUS_W-1:0] HOLD_ALL_FLUSH = {STAGES{HOLD_FLUSH}};

endpackage

// File: rtl/pipe_hold_ctrl_stall_wait_timer.sv
// Counts consecutive bus-wait cycles and pulses once when the wait reaches TIMEOUT cycles.
// The counter saturates, so a long wait produces exactly one pulse until a free cycle clears it.
module stall_wait_timer #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!stall_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = !rst && stall_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Merges per-stage stall requests and the EX redirect into one hold vector for the register chain.
// A jump arriving under a memory wait is parked in PEND and replayed on the first free cycle.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ifetch_wait_i,
    input  logic                   ld_use_i,
    input  logic                   ex_busy_i,
    input  logic                   mem_wait_i,
    input  logic                   jump_req_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    output logic [HOLD_BUS_W-1:0]  hold_o,
    output logic                   jump_flag_o,
    output logic [INST_ADDR_W-1:0] jump_addr_o,
    output logic                   stall_timeout_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [INST_ADDR_W-1:0] pend_addr_q;
    logic [INST_ADDR_W-1:0] pend_addr_d;

    logic [HOLD_BUS_W-1:0]  hold_run;
    logic                   jump_flag_run;
    logic [INST_ADDR_W-1:0] jump_addr_run;

    // Stall priority and parking decision; reset overrides the result further down.
    always_comb begin
        state_d       = state_q;
        pend_addr_d   = pend_addr_q;
        hold_run      = HOLD_ALL_NO;
        jump_flag_run = JUMP_DISABLE;
        jump_addr_run = '0;

        unique case (state_q)
            ST_RUN: begin
                if (mem_wait_i) begin
                    hold_run = HOLD_ALL_WAIT;
                    if (jump_req_i) begin
                        pend_addr_d = jump_addr_i;
                        state_d     = ST_PEND;
                    end
                end else if (ex_busy_i) begin
                    hold_run = pack_hold(HOLD_FLUSH, HOLD_WAIT, HOLD_WAIT, HOLD_WAIT);
                end else if (jump_req_i) begin
                    hold_run      = pack_hold(HOLD_NO, HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH);
                    jump_flag_run = JUMP_ENABLE;
                    jump_addr_run = jump_addr_i;
                end else if (ld_use_i) begin
                    hold_run = pack_hold(HOLD_NO, HOLD_FLUSH, HOLD_WAIT, HOLD_WAIT);
                end else if (ifetch_wait_i) begin
                    hold_run = pack_hold(HOLD_NO, HOLD_NO, HOLD_FLUSH, HOLD_WAIT);
                end
            end
            ST_PEND: begin
                // EX is frozen under the wait, so any jump_req_i seen here is the parked one.
                if (mem_wait_i) begin
                    hold_run = HOLD_ALL_WAIT;
                end else begin
                    hold_run      = pack_hold(HOLD_NO, HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH);
                    jump_flag_run = JUMP_ENABLE;
                    jump_addr_run = pend_addr_q;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign hold_o      = rst ? HOLD_ALL_FLUSH : hold_run;
    assign jump_flag_o = rst ? JUMP_DISABLE   : jump_flag_run;
    assign jump_addr_o = rst ? '0             : jump_addr_run;

    stall_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .stall_i   (mem_wait_i | ifetch_wait_i),
        .timeout_o (stall_timeout_o)
    );

endmodule
